// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the register file's single write port between two producers:
//   * primary   : the in-order pipeline write-back stage
//   * secondary : a multi-cycle unit (mul/div, late load), buffered in a
//                 small circular queue
// Primary results that overflowed, and writes to $0 from either source,
// are consumed without touching the register file. The register file
// write enable, address and data are driven from registers, so a grant in
// cycle N becomes a write in cycle N+1.
//
// Optional feature (macro RF_WB_STARVE_GUARD_EN):
//   defined     : a queued entry that loses arbitration STARVE_MAX times in
//                 a row is granted in a FORCE cycle that stalls the primary.
//   not defined : strict primary priority; the queue drains only in cycles
//                 with p_valid=0 and p_stall is tied low.
//
// Parameters
//   DATA_W     write data width
//   ADDR_W     register address width
//   QDEPTH     secondary queue depth (power of two, >= 2)
//   STARVE_MAX lost arbitration cycles before a forced grant (1..15)
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   p_valid/p_addr/p_data/p_ovf primary write-back request
//   p_stall                     primary not accepted; hold p_* stable
//   s_valid/s_addr/s_data       secondary result, pushed when s_ready=1
//   s_ready                     queue not full (registered count only)
//   rf_we/rf_waddr/rf_wdata     register file write port
//   q_count                     current queue occupancy
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     p_valid,
  input  logic [ADDR_W-1:0]        p_addr,
  input  logic [DATA_W-1:0]        p_data,
  input  logic                     p_ovf,
  output logic                     p_stall,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [ADDR_W-1:0]        s_addr,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [$clog2(QDEPTH):0]  q_count
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH) + 1;

  // Elaboration-time guard against unsupported configurations.
  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 ||
      STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
    $error("regfile_wb_arbiter: unsupported QDEPTH/STARVE_MAX");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,   // queue empty
    ST_WAIT  = 2'd1    // queue non-empty, primary wins
`ifdef RF_WB_STARVE_GUARD_EN
    ,ST_FORCE = 2'd2   // queue head granted, primary stalled
`endif
  } state_t;

  state_t state, state_next;

  // Secondary queue storage and pointers. Pointers wrap naturally because
  // QDEPTH is a power of two.
  logic [ADDR_W-1:0] q_addr [QDEPTH];
  logic [DATA_W-1:0] q_data [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_next;

  logic              grant_p, grant_s;
  logic              push, pop;
  logic              wr_sel_p, wr_sel_s;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

`ifdef RF_WB_STARVE_GUARD_EN
  logic [3:0] starve_cnt, starve_next;
`endif

  assign head_addr = q_addr[rd_ptr];
  assign head_data = q_data[rd_ptr];

  // Full check uses the registered count only: no push into a full queue
  // even if a pop happens in the same cycle.
  assign s_ready = (q_count != CNT_W'(QDEPTH));
  assign push    = s_valid && s_ready;
  assign pop     = grant_s;

`ifdef RF_WB_STARVE_GUARD_EN
  assign p_stall = (state == ST_FORCE);
`else
  assign p_stall = 1'b0;
`endif

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_p    = 1'b0;
    grant_s    = 1'b0;
    state_next = state;

    case (state)
      ST_IDLE: grant_p = p_valid;
      ST_WAIT: begin
        if (p_valid) grant_p = 1'b1;
        else         grant_s = 1'b1;
      end
`ifdef RF_WB_STARVE_GUARD_EN
      ST_FORCE: grant_s = 1'b1;
`endif
      default: ;
    endcase

    count_next = q_count + CNT_W'(push) - CNT_W'(pop);

`ifdef RF_WB_STARVE_GUARD_EN
    starve_next = starve_cnt;
    if (grant_s)
      starve_next = 4'd0;
    else if (state == ST_WAIT && grant_p && starve_cnt != 4'hF)
      starve_next = starve_cnt + 4'd1;
`endif

    case (state)
      ST_IDLE: if (push) state_next = ST_WAIT;
      ST_WAIT: begin
`ifdef RF_WB_STARVE_GUARD_EN
        // The head just lost its STARVE_MAX-th consecutive cycle.
        if (grant_p && starve_next == 4'(STARVE_MAX))
          state_next = ST_FORCE;
        else
`endif
        if (count_next == '0)
          state_next = ST_IDLE;
      end
`ifdef RF_WB_STARVE_GUARD_EN
      ST_FORCE: state_next = (count_next == '0) ? ST_IDLE : ST_WAIT;
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Overflowed primary results and writes to $0 are consumed silently.
  assign wr_sel_p = grant_p && !p_ovf && (p_addr != '0);
  assign wr_sel_s = grant_s && (head_addr != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      q_count  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
`ifdef RF_WB_STARVE_GUARD_EN
      starve_cnt <= 4'd0;
`endif
    end else begin
      state   <= state_next;
      q_count <= count_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
`ifdef RF_WB_STARVE_GUARD_EN
      starve_cnt <= starve_next;
`endif
      rf_we <= wr_sel_p || wr_sel_s;
      if (wr_sel_p) begin
        rf_waddr <= p_addr;
        rf_wdata <= p_data;
      end else if (wr_sel_s) begin
        rf_waddr <= head_addr;
        rf_wdata <= head_data;
      end
    end
  end

  // NOTE: queue storage has no reset; validity is tracked entirely by the
  // pointers and count, so clearing the entries would only cost area.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= s_addr;
      q_data[wr_ptr] <= s_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed bench for regfile_wb_arbiter with a scoreboard: stimulus pushes
// the expected register file writes (cycle, address, data) into a queue and
// a monitor on the falling edge pops and compares every rf_we pulse.
// Inputs are driven on the falling edge; the DUT outputs are registered or
// derived from registered state only, so sampling on the same edge is safe.
// Expectations depend on RF_WB_STARVE_GUARD_EN for the starvation scenario.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        p_valid;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        p_ovf;
  logic        p_stall;
  logic        s_valid;
  logic        s_ready;
  logic [4:0]  s_addr;
  logic [31:0] s_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  q_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          c;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  regfile_wb_arbiter #(
    .DATA_W(32), .ADDR_W(5), .QDEPTH(2), .STARVE_MAX(3)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .p_valid  (p_valid),
    .p_addr   (p_addr),
    .p_data   (p_data),
    .p_ovf    (p_ovf),
    .p_stall  (p_stall),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_addr   (s_addr),
    .s_data   (s_data),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .q_count  (q_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic expect_wr(input int c, input logic [4:0] a,
                           input logic [31:0] d);
    exp_t e;
    e.c = c; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_idle();
    p_valid = 1'b0; p_addr = '0; p_data = '0; p_ovf = 1'b0;
    s_valid = 1'b0; s_addr = '0; s_data = '0;
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn === 1'b1 && rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got r%0d=0x%0h expected no write (cycle %0d)",
                 rf_waddr, rf_wdata, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_cycle", 64'(cyc), 64'(e.c));
        check("wr_addr", 64'(rf_waddr), 64'(e.addr));
        check("wr_data", 64'(rf_wdata), 64'(e.data));
      end
    end
  end

  // Hard time limit: the directed sequence is a few hundred cycles at most.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    drive_idle();
    resetn = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    check("rst_p_stall", 64'(p_stall), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_q_count", 64'(q_count), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Primary write r8 <= 0x1234, one-cycle latency
    p_valid = 1'b1; p_addr = 5'd8; p_data = 32'h1234;
    expect_wr(cyc + 1, 5'd8, 32'h1234);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    check("single_pulse_we", 64'(rf_we), 64'd0);

    // Overflowed primary, then primary to $0: consumed without writes
    p_valid = 1'b1; p_ovf = 1'b1; p_addr = 5'd9; p_data = 32'h99;
    check("ovf_p_stall", 64'(p_stall), 64'd0);
    @(negedge clk);
    check("ovf_no_we", 64'(rf_we), 64'd0);
    p_ovf = 1'b0; p_addr = 5'd0; p_data = 32'h77;
    check("zero_p_stall", 64'(p_stall), 64'd0);
    @(negedge clk);
    check("zero_no_we", 64'(rf_we), 64'd0);
    drive_idle();
    @(negedge clk);

    // Secondary pushes (3,0xA),(4,0xB) with the primary idle
    s_valid = 1'b1; s_addr = 5'd3; s_data = 32'hA;
    expect_wr(cyc + 2, 5'd3, 32'hA);
    @(negedge clk);
    check("sec_q_count1", 64'(q_count), 64'd1);
    check("sec_s_ready", 64'(s_ready), 64'd1);
    s_addr = 5'd4; s_data = 32'hB;
    expect_wr(cyc + 2, 5'd4, 32'hB);
    @(negedge clk);
    check("sec_q_count_pushpop", 64'(q_count), 64'd1);
    s_valid = 1'b0;
    @(negedge clk);
    check("sec_q_count0", 64'(q_count), 64'd0);

    // Secondary write to $0 is popped without a write
    s_valid = 1'b1; s_addr = 5'd0; s_data = 32'hDEAD;
    @(negedge clk);
    s_valid = 1'b0;
    check("sec0_q_count1", 64'(q_count), 64'd1);
    @(negedge clk);
    check("sec0_q_count0", 64'(q_count), 64'd0);
    check("sec0_no_we", 64'(rf_we), 64'd0);
    @(negedge clk);

    // Starvation: primary held valid while (5,0xC) waits in the queue
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) begin
        p_valid = 1'b0;
        check("starve_end_stall", 64'(p_stall), 64'd0);
`ifndef RF_WB_STARVE_GUARD_EN
        check("starve_q_held", 64'(q_count), 64'd1);
        expect_wr(cyc + 1, 5'd5, 32'hC);
`else
        check("starve_q_drained", 64'(q_count), 64'd0);
`endif
      end else begin
        p_valid = 1'b1; p_addr = 5'd10;
        s_valid = (k == 0); s_addr = 5'd5; s_data = 32'hC;
`ifdef RF_WB_STARVE_GUARD_EN
        check("starve_p_stall", 64'(p_stall), 64'(k == 4));
        p_data = 32'h100 + 32'((k == 5) ? 4 : k);
        if (k <= 3) expect_wr(cyc + 1, 5'd10, 32'h100 + 32'(k));
        if (k == 4) begin
          expect_wr(cyc + 1, 5'd5, 32'hC);
          expect_wr(cyc + 2, 5'd10, 32'h104);
        end
`else
        check("starve_p_stall", 64'(p_stall), 64'd0);
        p_data = 32'h100 + 32'(k);
        expect_wr(cyc + 1, 5'd10, 32'h100 + 32'(k));
`endif
      end
      @(negedge clk);
    end
    drive_idle();
    repeat (2) @(negedge clk);
    check("starve_q_final", 64'(q_count), 64'd0);

    // Full queue with a pending push while a pop occurs
    p_valid = 1'b1; p_addr = 5'd11; p_data = 32'hE0;
    s_valid = 1'b1; s_addr = 5'd6; s_data = 32'h60;
    expect_wr(cyc + 1, 5'd11, 32'hE0);
    @(negedge clk);
    p_data = 32'hE1;
    s_addr = 5'd7; s_data = 32'h70;
    expect_wr(cyc + 1, 5'd11, 32'hE1);
    @(negedge clk);
    check("full_q_count", 64'(q_count), 64'd2);
    check("full_s_ready", 64'(s_ready), 64'd0);
    p_valid = 1'b0;
    s_addr = 5'd8; s_data = 32'h80;
    expect_wr(cyc + 1, 5'd6, 32'h60);
    @(negedge clk);
    check("after_pop_s_ready", 64'(s_ready), 64'd1);
    check("after_pop_q_count", 64'(q_count), 64'd1);
    expect_wr(cyc + 1, 5'd7, 32'h70);
    @(negedge clk);
    s_valid = 1'b0;
    expect_wr(cyc + 1, 5'd8, 32'h80);
    @(negedge clk);
    @(negedge clk);
    check("full_q_final", 64'(q_count), 64'd0);

    // Reset asserted while the queue is full
    p_valid = 1'b1; p_addr = 5'd12; p_data = 32'hF0;
    s_valid = 1'b1; s_addr = 5'd9; s_data = 32'h90;
    expect_wr(cyc + 1, 5'd12, 32'hF0);
    @(negedge clk);
    p_data = 32'hF1;
    s_addr = 5'd13; s_data = 32'hD0;
    expect_wr(cyc + 1, 5'd12, 32'hF1);
    @(negedge clk);
    check("prerst_q_count", 64'(q_count), 64'd2);
    p_data = 32'hF2;
    s_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("midrst_q_count", 64'(q_count), 64'd0);
    check("midrst_rf_we", 64'(rf_we), 64'd0);
    check("midrst_s_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    drive_idle();
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check("postrst_q_count", 64'(q_count), 64'd0);
    check("postrst_rf_we", 64'(rf_we), 64'd0);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
